obi_rr_arbiter: RTL and testbench
=================================

Name: obi_rr_arbiter

Overview:
- Shares one OBI slave port between NUM_MASTERS OBI masters, e.g. the wb_to_obi bridge plus a DMA/debug master feeding one SRAM macro or peripheral bus.
- Round-robin arbitration on the address phase.
- A small in-order ID FIFO records which master won each accepted transaction, so every response-phase rvalid/rdata is steered back to the right master.

Parameters:
NUM_MASTERS, 2, number of requesting OBI masters (2..8)
MAX_OUTSTANDING, 2, accepted-but-unanswered transactions allowed on slave port (1..4, power of 2)
IDW, $clog2(NUM_MASTERS) (min 1), master index width

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
m_req_i  in  NUM_MASTERS  per-master OBI req
m_gnt_o  out  NUM_MASTERS  per-master OBI gnt
m_addr_i  in  NUM_MASTERS*32  packed addresses, master k at [32k+31:32k]
m_we_i  in  NUM_MASTERS  write enables
m_be_i  in  NUM_MASTERS*4  packed byte enables
m_wdata_i  in  NUM_MASTERS*32  packed write data
m_rvalid_o  out  NUM_MASTERS  per-master response valid
m_rdata_o  out  32  response data, broadcast to all masters
s_req_o  out  1  slave req
s_gnt_i  in  1  slave gnt
s_addr_o  out  32  slave address
s_we_o  out  1  slave write enable
s_be_o  out  4  slave byte enables
s_wdata_o  out  32  slave write data
s_rvalid_i  in  1  slave response valid
s_rdata_i  in  32  slave response data

Behaviour:
- Reset (async assert, sync deassert in the reset tree):
  - rr_ptr=0, lock=0, FIFO empty.
  - All outputs 0: s_req_o, m_gnt_o, m_rvalid_o.
  - m_rdata_o follows s_rdata_i.
- Protocol: every accepted transaction (read or write) gets exactly one s_rvalid_i pulse, in order, no earlier than the cycle after acceptance.
- Selection (combinational):
  - winner = first requesting master at or after rr_ptr, wrapping modulo NUM_MASTERS.
  - If lock=1, winner = locked_id regardless of other requests.
- Address path:
  - s_req_o = any m_req_i && !fifo_full.
  - s_addr/we/be/wdata are muxed from the winner; all zero when s_req_o=0.
  - m_gnt_o[winner] = s_gnt_i && s_req_o; all other gnt bits are 0. Zero-latency gnt passthrough.
- Accept = s_req_o && s_gnt_i. On accept:
  - push winner into FIFO;
  - rr_ptr <= (winner+1) mod NUM_MASTERS;
  - lock <= 0.
- Lock (OBI stability rule):
  - If s_req_o=1 && s_gnt_i=0: lock <= 1, locked_id <= winner. The same master stays selected until granted, even if a higher-priority requester arrives.
  - The locked master must not drop req (OBI rule). If it does, lock clears the next cycle; flag it with an assertion, not in RTL.
- Response path:
  - m_rvalid_o[fifo_head] = s_rvalid_i; FIFO pops on s_rvalid_i.
  - s_rvalid_i with an empty FIFO is ignored (no pulse out); assertion flags it.
- Simultaneous accept and rvalid with FIFO full: a push is not possible, because s_req_o is low when full. The pop makes room one cycle later; no same-cycle bypass.
- Simultaneous accept and rvalid with FIFO non-full: push and pop in the same cycle; count unchanged.
- Pointer arithmetic wraps modulo MAX_OUTSTANDING (power of 2, natural overflow). Count width is $clog2(MAX_OUTSTANDING)+1.
- Reset mid-transaction: FIFO and lock cleared immediately. Any late slave rvalid is dropped by the empty-FIFO rule.
- Single-master case: pure passthrough with outstanding limiting.

Decomposition:
- obi_pkg holds:
  - OBI_AW=32, OBI_DW=32, OBI_BEW=4;
  - typedef obi_req_t (addr, we, be, wdata);
  - typedef obi_rsp_t (rdata).
- Sub-module obi_id_fifo:
  - parameters DEPTH, WIDTH;
  - ports push/pop/full/empty/head;
  - async active-low reset.
- Arbiter core (rr pointer, lock, mux) stays in obi_rr_arbiter.

Test Plan:
- Two masters request reads every cycle, slave gnt=1, rvalid 1 cycle later → grants alternate M0,M1,M0,M1; each m_rvalid_o pulse goes to the matching master; rdata 0xA0000000+addr matches.
- M0 requests with s_gnt_i=0 for 3 cycles, M1 raises req in cycle 2 → s_addr_o stays at M0's address; M0 granted first in cycle 4, M1 next.
- MAX_OUTSTANDING=2, slave grants but holds rvalid 5 cycles → third request sees s_req_o=0 until the first rvalid, then proceeds the following cycle.
- Write M1 (addr 0x10, be 0x3, wdata 0xDEADBEEF) then read M0 (addr 0x10) → slave sees the exact write fields; the first rvalid goes to M1, the second to M0 with rdata 0x0000BEEF.
- Assert rst_ni low with 2 transactions outstanding, release, inject a stale s_rvalid_i → no m_rvalid_o pulse, rr_ptr=0, first new grant goes to M0.
- Same-cycle accept and rvalid at count=1 → count stays 1; routing stays correct for both transactions.

Source files
------------

// File: rtl/obi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : obi_pkg
// Brief    : Shared OBI widths and request/response bundles for the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package obi_pkg;

  localparam int OBI_AW  = 32;
  localparam int OBI_DW  = 32;
  localparam int OBI_BEW = 4;

  // Address-phase fields that travel from a master to the slave port.
  typedef struct packed {
    logic [OBI_AW-1:0]  addr;
    logic               we;
    logic [OBI_BEW-1:0] be;
    logic [OBI_DW-1:0]  wdata;
  } obi_req_t;

  // Response-phase payload returned by the slave.
  typedef struct packed {
    logic [OBI_DW-1:0] rdata;
  } obi_rsp_t;

endpackage : obi_pkg
`default_nettype wire

// File: rtl/obi_id_fifo.sv
`default_nettype none
// ============================================================================
// Module   : obi_id_fifo
// Brief    : Small in-order FIFO holding the master index of every accepted
//            transaction so responses can be steered back to their owner.
// Revision : 1.0 - initial release
// ============================================================================
module obi_id_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q,  count_d;
  logic             w_do_push;
  logic             w_do_pop;

  assign full_o    = (count_q == CW'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign head_o    = mem_q[rd_ptr_q];
  assign w_do_push = push_i && !full_o;
  assign w_do_pop  = pop_i && !empty_o;

  // Pointer/count next state; the last-slot compare equals natural wrap for
  // power-of-two depths and also keeps a depth-1 FIFO pinned at slot 0.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (w_do_push) begin
      wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
    end
    if (w_do_pop) begin
      rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
    end
    if (w_do_push && !w_do_pop) begin
      count_d = count_q + CW'(1);
    end else if (w_do_pop && !w_do_push) begin
      count_d = count_q - CW'(1);
    end
  end

  // Pointer and occupancy registers, cleared immediately on reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: a slot is only read after it has been written.
  always_ff @(posedge clk_i) begin
    if (w_do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule : obi_id_fifo
`default_nettype wire

// File: rtl/obi_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : obi_rr_arbiter
// Brief    : Round-robin arbiter sharing one OBI slave port between several
//            OBI masters, with in-order response steering via an ID FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module obi_rr_arbiter
  import obi_pkg::*;
#(
  parameter int NUM_MASTERS     = 2,
  parameter int MAX_OUTSTANDING = 2,
  parameter int IDW             = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NUM_MASTERS-1:0]         m_req_i,
  output logic [NUM_MASTERS-1:0]         m_gnt_o,
  input  logic [NUM_MASTERS*OBI_AW-1:0]  m_addr_i,
  input  logic [NUM_MASTERS-1:0]         m_we_i,
  input  logic [NUM_MASTERS*OBI_BEW-1:0] m_be_i,
  input  logic [NUM_MASTERS*OBI_DW-1:0]  m_wdata_i,
  output logic [NUM_MASTERS-1:0]         m_rvalid_o,
  output logic [OBI_DW-1:0]              m_rdata_o,
  output logic                           s_req_o,
  input  logic                           s_gnt_i,
  output logic [OBI_AW-1:0]              s_addr_o,
  output logic                           s_we_o,
  output logic [OBI_BEW-1:0]             s_be_o,
  output logic [OBI_DW-1:0]              s_wdata_o,
  input  logic                           s_rvalid_i,
  input  logic [OBI_DW-1:0]              s_rdata_i
);

  obi_req_t         w_req [NUM_MASTERS];
  obi_req_t         w_sel;
  obi_rsp_t         w_rsp;

  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic             lock_q, lock_d;
  logic [IDW-1:0]   locked_id_q, locked_id_d;

  logic [IDW-1:0]   w_rr_winner;
  logic             w_rr_found;
  logic [IDW-1:0]   w_winner;
  logic             w_lock_hold;
  logic             w_accept;
  logic             w_full;
  logic             w_empty;
  logic [IDW-1:0]   w_head;
  int               w_idx;

  // Unpack the flat per-master buses into request structs.
  for (genvar k = 0; k < NUM_MASTERS; k++) begin : g_unpack
    assign w_req[k].addr  = m_addr_i[OBI_AW*k +: OBI_AW];
    assign w_req[k].we    = m_we_i[k];
    assign w_req[k].be    = m_be_i[OBI_BEW*k +: OBI_BEW];
    assign w_req[k].wdata = m_wdata_i[OBI_DW*k +: OBI_DW];
  end

  // Round-robin search: first requester at or after rr_ptr, wrapping.
  always_comb begin
    w_rr_winner = rr_ptr_q;
    w_rr_found  = 1'b0;
    w_idx       = 0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      w_idx = (int'(rr_ptr_q) + i) % NUM_MASTERS;
      if (!w_rr_found && m_req_i[IDW'(w_idx)]) begin
        w_rr_winner = IDW'(w_idx);
        w_rr_found  = 1'b1;
      end
    end
  end

  // A stalled (requested but not granted) master keeps the port until it is
  // granted; if it illegally drops req the lock is ignored from that cycle.
  assign w_lock_hold = lock_q && m_req_i[locked_id_q];
  assign w_winner    = w_lock_hold ? locked_id_q : w_rr_winner;

  assign s_req_o  = (|m_req_i) && !w_full;
  assign w_accept = s_req_o && s_gnt_i;
  assign w_sel    = w_req[w_winner];

  // Address-phase mux with fields forced to zero while the port is idle.
  always_comb begin
    s_addr_o  = '0;
    s_we_o    = 1'b0;
    s_be_o    = '0;
    s_wdata_o = '0;
    if (s_req_o) begin
      s_addr_o  = w_sel.addr;
      s_we_o    = w_sel.we;
      s_be_o    = w_sel.be;
      s_wdata_o = w_sel.wdata;
    end
  end

  // Zero-latency grant passthrough to the winning master only.
  always_comb begin
    m_gnt_o = '0;
    if (w_accept) begin
      m_gnt_o[w_winner] = 1'b1;
    end
  end

  // Response steering to the oldest outstanding owner; stray rvalids dropped.
  always_comb begin
    m_rvalid_o = '0;
    if (s_rvalid_i && !w_empty) begin
      m_rvalid_o[w_head] = 1'b1;
    end
  end

  assign w_rsp.rdata = s_rdata_i;
  assign m_rdata_o   = w_rsp.rdata;

  // Next-state for the round-robin pointer and the stability lock.
  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    lock_d      = s_req_o && !s_gnt_i;
    locked_id_d = locked_id_q;
    if (w_accept) begin
      rr_ptr_d = (w_winner == IDW'(NUM_MASTERS - 1)) ? '0 : w_winner + IDW'(1);
    end
    if (lock_d) begin
      locked_id_d = w_winner;
    end
  end

  // Arbitration state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q    <= '0;
      lock_q      <= 1'b0;
      locked_id_q <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      lock_q      <= lock_d;
      locked_id_q <= locked_id_d;
    end
  end

  obi_id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (IDW)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (w_accept),
    .data_i  (w_winner),
    .pop_i   (s_rvalid_i),
    .full_o  (w_full),
    .empty_o (w_empty),
    .head_o  (w_head)
  );

`ifdef OBI_RR_ARBITER_CHECKS
  // Protocol checks: a locked master must hold req, and the slave must not
  // answer when nothing is outstanding.
  always @(posedge clk_i) begin
    if (rst_ni) begin
      assert (!(lock_q && !m_req_i[locked_id_q]))
        else $warning("obi_rr_arbiter: locked master dropped req");
      assert (!(s_rvalid_i && w_empty))
        else $warning("obi_rr_arbiter: rvalid with no outstanding transaction");
    end
  end
`endif

endmodule : obi_rr_arbiter
`default_nettype wire

// File: tb/tb_obi_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_obi_rr_arbiter
// Brief    : Directed self-checking bench for obi_rr_arbiter (2 masters,
//            2 outstanding).
// Revision : 1.0 - initial release
// ============================================================================
module tb_obi_rr_arbiter;

  localparam int N  = 2;
  localparam int MO = 2;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic [N-1:0]  m_req_i;
  logic [N-1:0]  m_gnt_o;
  logic [N*32-1:0] m_addr_i;
  logic [N-1:0]  m_we_i;
  logic [N*4-1:0] m_be_i;
  logic [N*32-1:0] m_wdata_i;
  logic [N-1:0]  m_rvalid_o;
  logic [31:0]   m_rdata_o;
  logic          s_req_o;
  logic          s_gnt_i;
  logic [31:0]   s_addr_o;
  logic          s_we_o;
  logic [3:0]    s_be_o;
  logic [31:0]   s_wdata_o;
  logic          s_rvalid_i;
  logic [31:0]   s_rdata_i;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  obi_rr_arbiter #(
    .NUM_MASTERS     (N),
    .MAX_OUTSTANDING (MO)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .m_req_i    (m_req_i),
    .m_gnt_o    (m_gnt_o),
    .m_addr_i   (m_addr_i),
    .m_we_i     (m_we_i),
    .m_be_i     (m_be_i),
    .m_wdata_i  (m_wdata_i),
    .m_rvalid_o (m_rvalid_o),
    .m_rdata_o  (m_rdata_o),
    .s_req_o    (s_req_o),
    .s_gnt_i    (s_gnt_i),
    .s_addr_o   (s_addr_o),
    .s_we_o     (s_we_o),
    .s_be_o     (s_be_o),
    .s_wdata_o  (s_wdata_o),
    .s_rvalid_i (s_rvalid_i),
    .s_rdata_i  (s_rdata_i)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
      else begin
        n_err++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_m(input int k, input logic req, input logic we,
                         input logic [3:0] be, input logic [31:0] addr,
                         input logic [31:0] wdata);
    m_req_i[k]           = req;
    m_we_i[k]            = we;
    m_be_i[4*k +: 4]     = be;
    m_addr_i[32*k +: 32] = addr;
    m_wdata_i[32*k +: 32] = wdata;
  endtask

  initial begin
    rst_ni     = 1'b0;
    m_req_i    = '0;
    m_addr_i   = '0;
    m_we_i     = '0;
    m_be_i     = '0;
    m_wdata_i  = '0;
    s_gnt_i    = 1'b0;
    s_rvalid_i = 1'b0;
    s_rdata_i  = 32'h0000_1234;

    // ---------------- reset state
    tick();
    tick();
    chk("rst_s_req",  {31'd0, s_req_o}, 32'd0);
    chk("rst_gnt",    {30'd0, m_gnt_o}, 32'd0);
    chk("rst_rvalid", {30'd0, m_rvalid_o}, 32'd0);
    chk("rst_rdata",  m_rdata_o, 32'h0000_1234);
    chk("rst_rrptr",  32'(dut.rr_ptr_q), 32'd0);
    rst_ni = 1'b1;

    // ---------------- round robin, both masters requesting every cycle
    tick();
    drive_m(0, 1'b1, 1'b0, 4'hF, 32'h0000_0100, 32'd0);
    drive_m(1, 1'b1, 1'b0, 4'hF, 32'h0000_0200, 32'd0);
    s_gnt_i = 1'b1;
    #1;
    chk("rr1_gnt",  {30'd0, m_gnt_o}, 32'd1);
    chk("rr1_addr", s_addr_o, 32'h0000_0100);
    tick();
    s_rvalid_i = 1'b1;
    s_rdata_i  = 32'hA000_0100;
    #1;
    chk("rr2_gnt",    {30'd0, m_gnt_o}, 32'd2);
    chk("rr2_addr",   s_addr_o, 32'h0000_0200);
    chk("rr2_rvalid", {30'd0, m_rvalid_o}, 32'd1);
    chk("rr2_rdata",  m_rdata_o, 32'hA000_0100);
    tick();
    s_rdata_i = 32'hA000_0200;
    #1;
    chk("rr3_gnt",    {30'd0, m_gnt_o}, 32'd1);
    chk("rr3_rvalid", {30'd0, m_rvalid_o}, 32'd2);
    chk("rr3_rdata",  m_rdata_o, 32'hA000_0200);
    tick();
    m_req_i   = '0;
    s_rdata_i = 32'hA000_0100;
    #1;
    chk("rr4_s_req",  {31'd0, s_req_o}, 32'd0);
    chk("rr4_gnt",    {30'd0, m_gnt_o}, 32'd0);
    chk("rr4_rvalid", {30'd0, m_rvalid_o}, 32'd1);
    tick();
    s_rvalid_i = 1'b0;
    s_gnt_i    = 1'b0;

    // ---------------- lock: M0 stalled, M1 arrives, M0 must stay selected
    drive_m(0, 1'b1, 1'b0, 4'hF, 32'h0000_0300, 32'd0);
    #1;
    chk("lk1_s_req", {31'd0, s_req_o}, 32'd1);
    chk("lk1_addr",  s_addr_o, 32'h0000_0300);
    chk("lk1_gnt",   {30'd0, m_gnt_o}, 32'd0);
    tick();
    drive_m(1, 1'b1, 1'b0, 4'hF, 32'h0000_0400, 32'd0);
    #1;
    chk("lk2_addr", s_addr_o, 32'h0000_0300);
    chk("lk2_gnt",  {30'd0, m_gnt_o}, 32'd0);
    tick();
    #1;
    chk("lk3_addr", s_addr_o, 32'h0000_0300);
    tick();
    s_gnt_i = 1'b1;
    #1;
    chk("lk4_gnt",  {30'd0, m_gnt_o}, 32'd1);
    chk("lk4_addr", s_addr_o, 32'h0000_0300);
    tick();
    m_req_i[0] = 1'b0;
    #1;
    chk("lk5_gnt",  {30'd0, m_gnt_o}, 32'd2);
    chk("lk5_addr", s_addr_o, 32'h0000_0400);
    tick();
    m_req_i    = '0;
    s_gnt_i    = 1'b0;
    s_rvalid_i = 1'b1;
    #1;
    chk("lk6_rvalid", {30'd0, m_rvalid_o}, 32'd1);
    tick();
    #1;
    chk("lk7_rvalid", {30'd0, m_rvalid_o}, 32'd2);
    tick();
    s_rvalid_i = 1'b0;

    // ---------------- outstanding limit: third request held off while full
    drive_m(0, 1'b1, 1'b0, 4'hF, 32'h0000_0500, 32'd0);
    s_gnt_i = 1'b1;
    #1;
    chk("ol1_gnt", {30'd0, m_gnt_o}, 32'd1);
    tick();
    drive_m(0, 1'b1, 1'b0, 4'hF, 32'h0000_0504, 32'd0);
    #1;
    chk("ol2_gnt", {30'd0, m_gnt_o}, 32'd1);
    tick();
    #1;
    chk("ol3_s_req", {31'd0, s_req_o}, 32'd0);
    chk("ol3_gnt",   {30'd0, m_gnt_o}, 32'd0);
    chk("ol3_count", 32'(dut.u_id_fifo.count_q), 32'd2);
    tick();
    #1;
    chk("ol4_s_req", {31'd0, s_req_o}, 32'd0);
    tick();
    s_rvalid_i = 1'b1;
    #1;
    chk("ol5_rvalid", {30'd0, m_rvalid_o}, 32'd1);
    chk("ol5_s_req",  {31'd0, s_req_o}, 32'd0);
    tick();
    s_rvalid_i = 1'b0;
    #1;
    chk("ol6_s_req", {31'd0, s_req_o}, 32'd1);
    chk("ol6_gnt",   {30'd0, m_gnt_o}, 32'd1);
    chk("ol6_addr",  s_addr_o, 32'h0000_0504);
    tick();
    m_req_i    = '0;
    s_rvalid_i = 1'b1;
    #1;
    chk("ol7_rvalid", {30'd0, m_rvalid_o}, 32'd1);
    tick();
    #1;
    chk("ol8_rvalid", {30'd0, m_rvalid_o}, 32'd1);
    tick();
    s_rvalid_i = 1'b0;

    // ---------------- write M1 then read M0; same-cycle push and pop
    drive_m(1, 1'b1, 1'b1, 4'h3, 32'h0000_0010, 32'hDEAD_BEEF);
    #1;
    chk("wr_gnt",   {30'd0, m_gnt_o}, 32'd2);
    chk("wr_addr",  s_addr_o, 32'h0000_0010);
    chk("wr_we",    {31'd0, s_we_o}, 32'd1);
    chk("wr_be",    {28'd0, s_be_o}, 32'h3);
    chk("wr_wdata", s_wdata_o, 32'hDEAD_BEEF);
    tick();
    drive_m(1, 1'b0, 1'b0, 4'h0, 32'd0, 32'd0);
    drive_m(0, 1'b1, 1'b0, 4'hF, 32'h0000_0010, 32'd0);
    s_rvalid_i = 1'b1;
    s_rdata_i  = 32'd0;
    #1;
    chk("rd_gnt",      {30'd0, m_gnt_o}, 32'd1);
    chk("rd_we",       {31'd0, s_we_o}, 32'd0);
    chk("wr_rvalid",   {30'd0, m_rvalid_o}, 32'd2);
    chk("pp_count_pre", 32'(dut.u_id_fifo.count_q), 32'd1);
    tick();
    m_req_i   = '0;
    s_rdata_i = 32'h0000_BEEF;
    #1;
    chk("pp_count_post", 32'(dut.u_id_fifo.count_q), 32'd1);
    chk("rd_rvalid",     {30'd0, m_rvalid_o}, 32'd1);
    chk("rd_rdata",      m_rdata_o, 32'h0000_BEEF);
    chk("idle_addr",     s_addr_o, 32'd0);
    tick();
    s_rvalid_i = 1'b0;
    s_gnt_i    = 1'b1;

    // ---------------- reset with two transactions outstanding
    drive_m(0, 1'b1, 1'b0, 4'hF, 32'h0000_0600, 32'd0);
    #1;
    chk("rs1_gnt", {30'd0, m_gnt_o}, 32'd1);
    tick();
    drive_m(0, 1'b0, 1'b0, 4'h0, 32'd0, 32'd0);
    drive_m(1, 1'b1, 1'b0, 4'hF, 32'h0000_0700, 32'd0);
    #1;
    chk("rs2_gnt", {30'd0, m_gnt_o}, 32'd2);
    tick();
    m_req_i = '0;
    s_gnt_i = 1'b0;
    #1;
    chk("rs_count_pre", 32'(dut.u_id_fifo.count_q), 32'd2);
    rst_ni = 1'b0;
    #1;
    chk("rs_count", 32'(dut.u_id_fifo.count_q), 32'd0);
    chk("rs_rrptr", 32'(dut.rr_ptr_q), 32'd0);
    chk("rs_lock",  {31'd0, dut.lock_q}, 32'd0);
    chk("rs_s_req", {31'd0, s_req_o}, 32'd0);
    tick();
    rst_ni     = 1'b1;
    s_rvalid_i = 1'b1;
    s_rdata_i  = 32'h0000_0055;
    #1;
    chk("stale_rvalid", {30'd0, m_rvalid_o}, 32'd0);
    chk("stale_rdata",  m_rdata_o, 32'h0000_0055);
    tick();
    s_rvalid_i = 1'b0;
    drive_m(0, 1'b1, 1'b0, 4'hF, 32'h0000_0800, 32'd0);
    drive_m(1, 1'b1, 1'b0, 4'hF, 32'h0000_0900, 32'd0);
    s_gnt_i = 1'b1;
    #1;
    chk("post_rst_gnt",  {30'd0, m_gnt_o}, 32'd1);
    chk("post_rst_addr", s_addr_o, 32'h0000_0800);
    tick();
    m_req_i    = '0;
    s_gnt_i    = 1'b0;
    s_rvalid_i = 1'b1;
    #1;
    chk("post_rst_rvalid", {30'd0, m_rvalid_o}, 32'd1);
    tick();
    s_rvalid_i = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_obi_rr_arbiter
`default_nettype wire
